// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives pc to instruction memory and registers {pc, instr} into IF/ID.
// Latency: address is combinational from pc; the word reaches IF/ID on the next edge.
// Backpressure: stall holds pc, IF/ID and fetch_count; redirect overrides stall and flushes IF/ID.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter logic [31:0] HALT_INSTR = 32'h00100073,
    parameter int          COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [63:0]        address,
    input  logic [31:0]        I,
    input  logic               stall,
    input  logic               redirect,
    input  logic [63:0]        redirect_target,
    output logic [63:0]        if_id_pc,
    output logic [31:0]        if_id_instr,
    output logic               if_id_valid,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        if_id_pc_q, if_id_pc_d;
    logic [31:0]        if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               fault_q, fault_d;
    logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // Wrong-path word is discarded whether or not the target is usable.
                    if_id_pc_d    = 64'h0;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_d = redirect_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (!stall) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = I;
                    if_id_valid_d = 1'b1;
                    fetch_count_d = fetch_count_q + 1'b1;
                    if (I == HALT_INSTR) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 64'd4;
                    end
                end
            end
            ST_HALT: begin
                // EBREAK stays visible while decode is stalled, then drains to a bubble.
                if (!stall) begin
                    if_id_pc_d    = 64'h0;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign address     = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed and random fetch/stall/redirect/reset traffic against a reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];

    // Main DUT (RESET_PC = 0)
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [63:0] redirect_target = 64'h0;
    logic [63:0] address, if_id_pc;
    logic [31:0] I, if_id_instr;
    logic        if_id_valid, halted, fault;
    logic [31:0] fetch_count;
    assign I = mem[address[7:2]];

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .address(address), .I(I), .stall(stall),
        .redirect(redirect), .redirect_target(redirect_target),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    // Second DUT exercising pc wrap at the top of the address space
    logic        reset_w = 1'b1, stall_w = 1'b0, redirect_w = 1'b0;
    logic [63:0] redirect_target_w = 64'h0;
    logic [63:0] address_w, if_id_pc_w;
    logic [31:0] I_w, if_id_instr_w;
    logic        if_id_valid_w, halted_w, fault_w;
    logic [31:0] fetch_count_w;
    assign I_w = mem[address_w[7:2]];

    instruction_fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .reset(reset_w), .address(address_w), .I(I_w), .stall(stall_w),
        .redirect(redirect_w), .redirect_target(redirect_target_w),
        .if_id_pc(if_id_pc_w), .if_id_instr(if_id_instr_w), .if_id_valid(if_id_valid_w),
        .halted(halted_w), .fault(fault_w), .fetch_count(fetch_count_w)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [63:0] m_pc, m_if_pc;
    logic [31:0] m_if_instr, m_count;
    logic        m_valid, m_halted, m_fault;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        m_if_pc    = 64'h0;
        m_if_instr = NOP;
        m_valid    = 1'b0;
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic s, input logic rd, input logic [63:0] t);
        logic [31:0] word;
        reset = r; stall = s; redirect = rd; redirect_target = t;
        word = mem[(m_pc / 4) % 64];
        if (r) begin
            m_pc = 64'h0; m_count = 0; m_halted = 0; m_fault = 0;
            flush_model();
        end else if (!m_halted) begin
            if (rd) begin
                flush_model();
                if (t % 4 == 0) m_pc = t;
                else begin m_fault = 1; m_halted = 1; end
            end else if (!s) begin
                m_if_pc = m_pc; m_if_instr = word; m_valid = 1; m_count = m_count + 1;
                if (word == HALT) m_halted = 1;
                else m_pc = m_pc + 4;
            end
        end else if (!s) begin
            flush_model();
        end
        @(posedge clk);
        #1;
        chk("address", address, m_pc);
        chk("if_id_pc", if_id_pc, m_if_pc);
        chk("if_id_instr", {32'h0, if_id_instr}, {32'h0, m_if_instr});
        chk("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_valid});
        chk("halted", {63'h0, halted}, {63'h0, m_halted});
        chk("fault", {63'h0, fault}, {63'h0, m_fault});
        chk("fetch_count", {32'h0, fetch_count}, {32'h0, m_count});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0000_0033;
        end
        m_pc = 0; m_if_pc = 0; m_if_instr = NOP; m_count = 0;
        m_valid = 0; m_halted = 0; m_fault = 0;

        // Reset state
        step(1, 0, 0, 0);
        reset_w = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        // Stall held at pc=8, then resume
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        // Redirect beats stall, then fetch from target
        step(0, 1, 1, 64'h40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Misaligned redirect faults and halts; later redirect ignored
        step(0, 0, 1, 64'h42);
        step(0, 0, 1, 64'h80);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        // EBREAK at address 12
        mem[3] = HALT;
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 64'h20);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);

        // Random traffic, with an occasional EBREAK planted in memory
        mem[3] = 32'h0000_0033;
        mem[$urandom_range(20, 63)] = HALT;
        for (int i = 0; i < 600; i++) begin
            logic        r, s, rd;
            logic [63:0] t;
            r  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 10);
            t  = {56'h0, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 99) < 85) t[1:0] = 2'b00;
            step(r, s, rd, t);
        end

        // Wrap instance: pc+4 from the top of memory wraps to 0
        reset_w = 1'b1;
        @(posedge clk); #1;
        chk("w_reset_address", address_w, WRAP_PC);
        chk("w_reset_valid", {63'h0, if_id_valid_w}, 64'h0);
        reset_w = 1'b0;
        @(posedge clk); #1;
        chk("w_address", address_w, 64'h0);
        chk("w_if_id_pc", if_id_pc_w, WRAP_PC);
        chk("w_if_id_instr", {32'h0, if_id_instr_w}, {32'h0, mem[63]});
        chk("w_if_id_valid", {63'h0, if_id_valid_w}, 64'h1);
        chk("w_fetch_count", {32'h0, fetch_count_w}, 64'h1);
        @(posedge clk); #1;
        reset_w = 1'b1;
        @(posedge clk); #1;
        chk("w_rst_address", address_w, WRAP_PC);
        chk("w_rst_if_id_pc", if_id_pc_w, 64'h0);
        chk("w_rst_if_id_instr", {32'h0, if_id_instr_w}, {32'h0, NOP});
        chk("w_rst_valid", {63'h0, if_id_valid_w}, 64'h0);
        chk("w_rst_halted", {63'h0, halted_w}, 64'h0);
        chk("w_rst_fault", {63'h0, fault_w}, 64'h0);
        chk("w_rst_count", {32'h0, fetch_count_w}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
